// File: rtl/icache_pkg.sv
// icache_pkg: shared address-split and frame types for the instruction cache
package icache_pkg;
    localparam int ITAG_W = 26;
    localparam int IIDX_W = 4;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        logic [31:0]       data;
    } icache_frame_t;
endpackage

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with a two-state fill FSM
module icache
    import icache_pkg::*;
#(
    parameter int          SETS    = 16,
    parameter logic [31:0] PC_INIT = 32'h0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic [31:0] imemload,
    output logic        ihit,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    typedef enum logic {IDLE, FETCH} state_t;

    state_t        state, next_state;
    icache_frame_t frames [SETS];
    icachef_t      req, miss_addr;
    logic          hit, fill;
    logic [35:0]   unused_bits;

    assign req         = icachef_t'(imemaddr);
    assign unused_bits = {PC_INIT, req.bytoff, miss_addr.bytoff};

    // hit/fill qualifiers; outputs are forced quiet while reset is held
    always_comb begin
        hit  = nRST && state == IDLE && imemREN && frames[req.idx].valid && frames[req.idx].tag == req.tag;
        fill = state == FETCH && !iwait;
    end

    // state register; reset wins over a fill completing on the same edge
    always_ff @(posedge CLK) begin
        state <= !nRST ? IDLE : next_state;
    end

    // next-state logic
    always_comb begin
        next_state = state;
        if (state == IDLE)
            next_state = (imemREN && !hit) ? FETCH : IDLE;
        else
            next_state = iwait ? FETCH : IDLE;
    end

    // output logic
    always_comb begin
        ihit     = hit;
        imemload = hit ? frames[req.idx].data : 32'h0;
        iREN     = nRST && state == FETCH;
        iaddr    = iREN ? {miss_addr[31:2], 2'b00} : 32'h0;
    end

    // frame array: valid bits clear together on reset, fills overwrite unconditionally
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++)
                frames[i].valid <= 1'b0;
        end else if (fill) begin
            frames[miss_addr.idx] <= '{valid: 1'b1, tag: miss_addr.tag, data: iload};
        end
    end

    // miss address latch and performance counters
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            miss_addr  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && imemREN && !hit)
                miss_addr <= req;
            if (hit)
                hit_count <= hit_count + 32'd1;
            if (fill)
                miss_count <= miss_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: randomized self-checking bench against an abstract cache model
module tb_icache;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic [31:0] imemload;
    logic        ihit;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload = '0;
    logic        iwait = 1'b1;
    logic [31:0] hit_count, miss_count;

    int tests = 0;
    int fails = 0;

    // model: what the cache should hold, keyed by word index
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];
    int unsigned exp_hits = 0;
    int unsigned exp_misses = 0;

    icache dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .imemload(imemload), .ihit(ihit), .iREN(iREN), .iaddr(iaddr),
        .iload(iload), .iwait(iwait), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[a[5:2]] && m_tag[a[5:2]] == a[31:6];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
    endtask

    // one IDLE request cycle; reports whether the model predicts a hit
    task automatic req_cycle(input logic [31:0] a, output bit h);
        @(posedge CLK); #1;
        imemREN = 1'b1; imemaddr = a; iwait = 1'b1;
        @(negedge CLK);
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_misses);
        h = model_hit(a);
        chk("ihit", {31'b0, ihit}, {31'b0, h});
        chk("imemload", imemload, h ? m_data[a[5:2]] : 32'h0);
        chk("iREN_idle", {31'b0, iREN}, 32'h0);
        if (h) exp_hits++;
    endtask

    // FETCH cycles for a miss on a; imemaddr is moved to b while filling
    task automatic fill(input logic [31:0] a, input int waits, input logic [31:0] b);
        logic [31:0] word;
        word = $urandom;
        for (int k = 0; k <= waits; k++) begin
            @(posedge CLK); #1;
            imemaddr = b;
            iwait = (k < waits);
            iload = (k == waits) ? word : $urandom;
            @(negedge CLK);
            chk("iREN_fetch", {31'b0, iREN}, 32'h1);
            chk("iaddr", iaddr, {a[31:2], 2'b00});
            chk("ihit_fetch", {31'b0, ihit}, 32'h0);
            chk("imemload_fetch", imemload, 32'h0);
        end
        m_valid[a[5:2]] = 1'b1;
        m_tag[a[5:2]]   = a[31:6];
        m_data[a[5:2]]  = word;
        exp_misses++;
    endtask

    task automatic fetch(input logic [31:0] a, input int waits, input logic [31:0] b);
        bit h;
        req_cycle(a, h);
        if (!h) begin
            fill(a, waits, b);
            req_cycle(b, h);
            if (!h) begin
                fill(b, waits, b);
                req_cycle(b, h);
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge CLK); #1;
        imemREN = 1'b0; imemaddr = $urandom; iwait = 1'b1;
        @(negedge CLK);
        chk("idle_ihit", {31'b0, ihit}, 32'h0);
        chk("idle_iREN", {31'b0, iREN}, 32'h0);
        chk("idle_imemload", imemload, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        nRST = 1'b0; imemREN = 1'b0; iwait = 1'b1;
        @(posedge CLK); #1;
        nRST = 1'b1;
        model_reset();
        @(negedge CLK);
        chk("rst_ihit", {31'b0, ihit}, 32'h0);
        chk("rst_iREN", {31'b0, iREN}, 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_hits", hit_count, 32'h0);
        chk("rst_misses", miss_count, 32'h0);
    endtask

    initial begin
        bit h;
        logic [31:0] a, b;
        model_reset();
        // reset held low: outputs quiet, counters clear
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rstlow_ihit", {31'b0, ihit}, 32'h0);
        chk("rstlow_imemload", imemload, 32'h0);
        chk("rstlow_iREN", {31'b0, iREN}, 32'h0);
        chk("rstlow_iaddr", iaddr, 32'h0);
        chk("rstlow_hits", hit_count, 32'h0);
        chk("rstlow_misses", miss_count, 32'h0);
        do_reset();

        // cold miss with two wait cycles, then repeat hit
        fetch(32'h0000_0000, 2, 32'h0000_0000);
        fetch(32'h0000_0000, 0, 32'h0000_0000);
        idle_cycle();

        // conflict eviction on index 0; index 1 stays resident
        fetch(32'h0000_0004, 1, 32'h0000_0004);
        fetch(32'h0000_0040, 0, 32'h0000_0040);
        fetch(32'h0000_0000, 1, 32'h0000_0000);
        fetch(32'h0000_0004, 0, 32'h0000_0004);

        // address moves from 0x10 to 0x20 while filling
        fetch(32'h0000_0010, 2, 32'h0000_0020);
        fetch(32'h0000_0010, 0, 32'h0000_0010);
        idle_cycle();

        // reset for one cycle mid-fill, colliding with fill completion
        req_cycle(32'h0000_0100, h);
        @(posedge CLK); #1;
        nRST = 1'b0; iwait = 1'b0; iload = 32'hDEAD_BEEF;
        @(negedge CLK);
        chk("midrst_iREN_low", {31'b0, iREN}, 32'h0);
        @(posedge CLK); #1;
        nRST = 1'b1; imemREN = 1'b0; iwait = 1'b1;
        model_reset();
        @(negedge CLK);
        chk("midrst_iREN_after", {31'b0, iREN}, 32'h0);
        chk("midrst_misses", miss_count, 32'h0);
        fetch(32'h0000_0100, 1, 32'h0000_0100);

        // random traffic over a small tag pool to force conflicts and re-hits
        for (int n = 0; n < 60; n++) begin
            a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
            b = ($urandom_range(0, 4) == 0) ? {24'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'b00} : a;
            if ($urandom_range(0, 5) == 0) idle_cycle();
            fetch(a, $urandom_range(0, 3), b);
        end
        idle_cycle();
        @(negedge CLK);
        chk("final_hits", hit_count, exp_hits);
        chk("final_misses", miss_count, exp_misses);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
